// File: rtl/adbg_cpu_seq_if.sv
// Request/response stream between the debug module's CPU command logic and
// the per-core access sequencer.
//   master : command side (drives req_*, rsp_ready_i; observes req_ready_o, rsp_*)
//   slave  : sequencer side (adbg_cpu_seq)
// Member names keep the sequencer-relative _i/_o suffixes of the original ports.
interface adbg_cpu_seq_if #(
  parameter int NB_CORES   = 4,
  parameter int CORE_IDX_W = (NB_CORES > 1) ? $clog2(NB_CORES) : 1
);
  logic                  req_valid_i;
  logic                  req_ready_o;
  logic                  req_we_i;
  logic [15:0]           req_addr_i;
  logic [31:0]           req_wdata_i;
  logic [NB_CORES-1:0]   req_core_mask_i;

  logic                  rsp_valid_o;
  logic                  rsp_ready_i;
  logic [CORE_IDX_W-1:0] rsp_core_o;
  logic [31:0]           rsp_rdata_o;
  logic                  rsp_timeout_o;
  logic                  rsp_err_o;
  logic                  rsp_last_o;

  modport master (
    output req_valid_i, req_we_i, req_addr_i, req_wdata_i, req_core_mask_i,
    output rsp_ready_i,
    input  req_ready_o,
    input  rsp_valid_o, rsp_core_o, rsp_rdata_o, rsp_timeout_o, rsp_err_o, rsp_last_o
  );

  modport slave (
    input  req_valid_i, req_we_i, req_addr_i, req_wdata_i, req_core_mask_i,
    input  rsp_ready_i,
    output req_ready_o,
    output rsp_valid_o, rsp_core_o, rsp_rdata_o, rsp_timeout_o, rsp_err_o, rsp_last_o
  );
endinterface

// File: rtl/adbg_cpu_seq.sv
// adbg_cpu_seq: shares one debug register-access request across NB_CORES
// CPU debug ports. A request carries a core mask; the access is issued to each
// selected core in ascending index order and one response is returned per
// core. Each access is bounded by a per-core timeout (TIMEOUT_CYCLES, 0 = none).
// Ports:
//   cpu_clk_i, cpu_rstn_i : clock, asynchronous active-low reset
//   bus (slave)           : req_* request stream in, rsp_* response stream out
//   busy_o                : a request is in progress
//   cpu_addr_o/cpu_data_o/cpu_we_o : latched request, driven to every core
//   cpu_stb_o             : strobe, only for the core currently accessed
//   cpu_ack_i/cpu_data_i  : per-core ack and read data
module adbg_cpu_seq #(
  parameter int NB_CORES       = 4,
  parameter int TIMEOUT_CYCLES = 255,
  parameter int CORE_IDX_W     = (NB_CORES > 1) ? $clog2(NB_CORES) : 1
) (
  input  logic                      cpu_clk_i,
  input  logic                      cpu_rstn_i,
  adbg_cpu_seq_if.slave             bus,
  output logic                      busy_o,
  output logic [NB_CORES-1:0][15:0] cpu_addr_o,
  output logic [NB_CORES-1:0][31:0] cpu_data_o,
  output logic [NB_CORES-1:0]       cpu_stb_o,
  output logic [NB_CORES-1:0]       cpu_we_o,
  input  logic [NB_CORES-1:0]       cpu_ack_i,
  input  logic [NB_CORES-1:0][31:0] cpu_data_i
);

  localparam int CNT_W = (TIMEOUT_CYCLES > 0) ? $clog2(TIMEOUT_CYCLES + 1) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST =
    (TIMEOUT_CYCLES > 0) ? CNT_W'(TIMEOUT_CYCLES - 1) : '0;

  typedef enum logic [1:0] {
    S_IDLE,
    S_ACCESS,
    S_RESP
  } state_e;

  state_e                state_q, state_d;
  logic                  we_q, we_d;
  logic [15:0]           addr_q, addr_d;
  logic [31:0]           wdata_q, wdata_d;
  logic [NB_CORES-1:0]   mask_q, mask_d;
  logic [CORE_IDX_W-1:0] tgt_q, tgt_d;
  logic [CNT_W-1:0]      cnt_q, cnt_d;
  logic [31:0]           rdata_q, rdata_d;
  logic                  timeout_q, timeout_d;
  logic                  err_q, err_d;

  logic [NB_CORES-1:0]   tgt_oh;
  logic [NB_CORES-1:0]   remaining;

  function automatic logic [CORE_IDX_W-1:0] lowest_idx(input logic [NB_CORES-1:0] m);
    logic                  found;
    logic [CORE_IDX_W-1:0] idx;
    found = 1'b0;
    idx   = '0;
    for (int unsigned i = 0; i < NB_CORES; i++) begin
      if (m[i] && !found) begin
        idx   = CORE_IDX_W'(i);
        found = 1'b1;
      end
    end
    return idx;
  endfunction

  assign tgt_oh    = NB_CORES'(1) << tgt_q;
  // Mask still to be served once the current target's response is consumed.
  assign remaining = mask_q & ~tgt_oh;

  always_comb begin
    state_d   = state_q;
    we_d      = we_q;
    addr_d    = addr_q;
    wdata_d   = wdata_q;
    mask_d    = mask_q;
    tgt_d     = tgt_q;
    cnt_d     = cnt_q;
    rdata_d   = rdata_q;
    timeout_d = timeout_q;
    err_d     = err_q;

    unique case (state_q)
      S_IDLE: begin
        if (bus.req_valid_i) begin
          we_d      = bus.req_we_i;
          addr_d    = bus.req_addr_i;
          wdata_d   = bus.req_wdata_i;
          mask_d    = bus.req_core_mask_i;
          tgt_d     = lowest_idx(bus.req_core_mask_i);
          cnt_d     = '0;
          rdata_d   = '0;
          timeout_d = 1'b0;
          // Empty mask still yields exactly one (error) response.
          err_d     = (bus.req_core_mask_i == '0);
          state_d   = (bus.req_core_mask_i == '0) ? S_RESP : S_ACCESS;
        end
      end

      S_ACCESS: begin
        cnt_d = cnt_q + 1'b1;
        // Ack has priority over a timeout expiring in the same cycle.
        if (cpu_ack_i[tgt_q]) begin
          rdata_d   = we_q ? '0 : cpu_data_i[tgt_q];
          timeout_d = 1'b0;
          state_d   = S_RESP;
        end else if ((TIMEOUT_CYCLES != 0) && (cnt_q == CNT_LAST)) begin
          rdata_d   = '0;
          timeout_d = 1'b1;
          state_d   = S_RESP;
        end
      end

      S_RESP: begin
        if (bus.rsp_ready_i) begin
          mask_d    = remaining;
          tgt_d     = lowest_idx(remaining);
          cnt_d     = '0;
          rdata_d   = '0;
          timeout_d = 1'b0;
          err_d     = 1'b0;
          state_d   = (remaining != '0) ? S_ACCESS : S_IDLE;
        end
      end

      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge cpu_clk_i or negedge cpu_rstn_i) begin
    if (!cpu_rstn_i) begin
      state_q   <= S_IDLE;
      we_q      <= 1'b0;
      addr_q    <= '0;
      wdata_q   <= '0;
      mask_q    <= '0;
      tgt_q     <= '0;
      cnt_q     <= '0;
      rdata_q   <= '0;
      timeout_q <= 1'b0;
      err_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      we_q      <= we_d;
      addr_q    <= addr_d;
      wdata_q   <= wdata_d;
      mask_q    <= mask_d;
      tgt_q     <= tgt_d;
      cnt_q     <= cnt_d;
      rdata_q   <= rdata_d;
      timeout_q <= timeout_d;
      err_q     <= err_d;
    end
  end

  assign bus.req_ready_o   = (state_q == S_IDLE);
  assign busy_o            = (state_q != S_IDLE);
  assign bus.rsp_valid_o   = (state_q == S_RESP);
  assign bus.rsp_core_o    = tgt_q;
  assign bus.rsp_rdata_o   = rdata_q;
  assign bus.rsp_timeout_o = timeout_q;
  assign bus.rsp_err_o     = err_q;
  assign bus.rsp_last_o    = (state_q == S_RESP) && (remaining == '0);

  assign cpu_addr_o = {NB_CORES{addr_q}};
  assign cpu_data_o = {NB_CORES{wdata_q}};
  assign cpu_we_o   = {NB_CORES{we_q}};
  assign cpu_stb_o  = (state_q == S_ACCESS) ? tgt_oh : '0;

endmodule
